// File: rtl/hist_compute_unit.sv
// Histogram compute unit: clears the shared histogram RAM, then bins a
// sample stream into it by read-modify-write with saturating counters, and
// finally holds done until the next start.
module hist_compute_unit #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_bin,
  input  logic              in_last,
  output logic              hist_ren_HCU,
  output logic              hist_wen_HCU,
  output logic [ADDR_W-1:0] hist_addr_HCU,
  output logic [DATA_W-1:0] hist_wdata_HCU,
  input  logic [DATA_W-1:0] hist_rdata_HCU,
  output logic              busy,
  output logic              done,
  output logic              sat_flag,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam logic [DATA_W-1:0] MAX_CNT   = '1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACC_RD,
    S_ACC_WR,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  clr_addr_reg;
  logic [ADDR_W-1:0]  bin_q_reg;
  logic               last_q_reg;
  logic               sat_flag_reg;
  logic [CNT_W-1:0]   sample_cnt_reg;

  // Bin already at its ceiling: the write-back keeps MAX and flags saturation.
  logic rd_sat;
  assign rd_sat = (hist_rdata_HCU == MAX_CNT);

  // A sample is taken only while waiting in the read phase.
  logic accept;
  assign accept = (state_reg == S_ACC_RD) && in_valid;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and RAM-side outputs; address/data stay at zero when the RAM is untouched.
  always_comb begin
    state_next     = state_reg;
    in_ready       = 1'b0;
    hist_ren_HCU   = 1'b0;
    hist_wen_HCU   = 1'b0;
    hist_addr_HCU  = '0;
    hist_wdata_HCU = '0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        hist_wen_HCU  = 1'b1;
        hist_addr_HCU = clr_addr_reg;
        if (clr_addr_reg == LAST_ADDR) state_next = S_ACC_RD;
      end
      S_ACC_RD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hist_ren_HCU  = 1'b1;
          hist_addr_HCU = in_bin;
          state_next    = S_ACC_WR;
        end
      end
      S_ACC_WR: begin
        hist_wen_HCU   = 1'b1;
        hist_addr_HCU  = bin_q_reg;
        hist_wdata_HCU = rd_sat ? MAX_CNT : hist_rdata_HCU + DATA_W'(1);
        state_next     = last_q_reg ? S_DONE : S_ACC_RD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Run bookkeeping: clear pointer, captured sample, sticky saturation, sample count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_reg   <= '0;
      bin_q_reg      <= '0;
      last_q_reg     <= 1'b0;
      sat_flag_reg   <= 1'b0;
      sample_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            clr_addr_reg   <= '0;
            sat_flag_reg   <= 1'b0;
            sample_cnt_reg <= '0;
          end
        end
        S_CLEAR: begin
          clr_addr_reg <= clr_addr_reg + ADDR_W'(1);
        end
        S_ACC_RD: begin
          if (accept) begin
            bin_q_reg      <= in_bin;
            last_q_reg     <= in_last;
            sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
          end
        end
        S_ACC_WR: begin
          if (rd_sat) sat_flag_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg == S_CLEAR) || (state_reg == S_ACC_RD) ||
                      (state_reg == S_ACC_WR);
  assign done       = (state_reg == S_DONE);
  assign sat_flag   = sat_flag_reg;
  assign sample_cnt = sample_cnt_reg;

endmodule

// File: tb/tb_hist_compute_unit.sv
// Testbench for hist_compute_unit: a RAM model answers the DUT, a reference
// histogram predicts every RAM read/write, and a monitor compares them.
module tb_hist_compute_unit;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 24;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MAXV   = (1 << DATA_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_bin;
  logic              in_last;
  logic              hist_ren_HCU;
  logic              hist_wen_HCU;
  logic [ADDR_W-1:0] hist_addr_HCU;
  logic [DATA_W-1:0] hist_wdata_HCU;
  logic [DATA_W-1:0] hist_rdata_HCU;
  logic              busy;
  logic              done;
  logic              sat_flag;
  logic [CNT_W-1:0]  sample_cnt;

  hist_compute_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_bin         (in_bin),
    .in_last        (in_last),
    .hist_ren_HCU   (hist_ren_HCU),
    .hist_wen_HCU   (hist_wen_HCU),
    .hist_addr_HCU  (hist_addr_HCU),
    .hist_wdata_HCU (hist_wdata_HCU),
    .hist_rdata_HCU (hist_rdata_HCU),
    .busy           (busy),
    .done           (done),
    .sat_flag       (sat_flag),
    .sample_cnt     (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];
  int  rq[$];

  int  n_checks = 0;
  int  n_fail   = 0;

  // Reference histogram and expected run status.
  int  ref_hist [DEPTH];
  int  exp_cnt;
  int  exp_sat;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // RAM model: preloaded with garbage so a missing clear shows up later.
  initial begin
    logic [DATA_W-1:0] ram [DEPTH];
    for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'($urandom);
    hist_rdata_HCU = '0;
    forever begin
      @(posedge clk);
      if (hist_ren_HCU) hist_rdata_HCU <= ram[hist_addr_HCU];
      if (hist_wen_HCU) ram[hist_addr_HCU] <= hist_wdata_HCU;
    end
  end

  // Monitor: compares every RAM access against the predicted queues.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (hist_ren_HCU && hist_wen_HCU) chk("ren_wen_overlap", 1, 0);
      if (!hist_ren_HCU && !hist_wen_HCU)
        chk("idle_addr_wdata", int'(hist_addr_HCU) | int'(hist_wdata_HCU), 0);
      if (hist_ren_HCU) begin
        if (rq.size() == 0) chk("unexpected_read", 1, 0);
        else chk("read_addr", int'(hist_addr_HCU), rq.pop_front());
      end
      if (hist_wen_HCU) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("write_addr", int'(hist_addr_HCU), e.addr);
          chk("write_data", int'(hist_wdata_HCU), e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_ren"}, int'(hist_ren_HCU), 0);
    chk({tag, "_wen"}, int'(hist_wen_HCU), 0);
    chk({tag, "_addr"}, int'(hist_addr_HCU), 0);
    chk({tag, "_wdata"}, int'(hist_wdata_HCU), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_sat"}, int'(sat_flag), 0);
    chk({tag, "_cnt"}, int'(sample_cnt), 0);
  endtask

  // Pulse start; expect a zero write to every address, optionally wait for it.
  task automatic do_start(input bit wait_clear);
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      ref_hist[i] = 0;
      wq.push_back('{addr: i, data: 0});
    end
    exp_cnt = 0;
    exp_sat = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", int'(busy), 1);
    chk("start_done", int'(done), 0);
    chk("start_sat", int'(sat_flag), 0);
    chk("start_cnt", int'(sample_cnt), 0);
    if (wait_clear) begin
      n = 0;
      for (int g = 0; g < DEPTH + 10; g++) begin
        if (in_ready) break;
        if (hist_wen_HCU) n++;
        @(negedge clk);
      end
      chk("clear_cycles", n, DEPTH);
      chk("clear_then_ready", int'(in_ready), 1);
      step();
    end
  endtask

  // Offer one sample (caller sits just after a rising edge); on acceptance
  // the reference predicts the read and the saturating write-back.
  task automatic send(input int bin, input bit last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_bin   = ADDR_W'(bin);
    in_last  = last;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      if (in_ready) begin
        int nv;
        rq.push_back(bin);
        if (ref_hist[bin] == MAXV) begin
          nv = MAXV;
          exp_sat = 1;
        end else begin
          nv = ref_hist[bin] + 1;
        end
        ref_hist[bin] = nv;
        wq.push_back('{addr: bin, data: nv});
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Let the pending write-back finish, then check run status.
  task automatic settle_and_check(input string tag);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_cnt"}, int'(sample_cnt), exp_cnt);
    chk({tag, "_sat"}, int'(sat_flag), exp_sat);
    step();
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int g = 0; g < 10; g++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, int'(seen), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_cnt"}, int'(sample_cnt), exp_cnt);
    chk({tag, "_sat"}, int'(sat_flag), exp_sat);
    step();
  endtask

  initial begin
    int held_cnt;
    bit hit;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_bin   = '0;
    in_last  = 1'b0;
    exp_cnt  = 0;
    exp_sat  = 0;
    for (int i = 0; i < DEPTH; i++) ref_hist[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset");

    // T1: full clear
    do_start(1'b1);

    // T2: single sample, check the read/write pair and ready pattern
    send(5, 1'b0);
    @(negedge clk);
    chk("t2_ready_wr", int'(in_ready), 0);
    chk("t2_wen", int'(hist_wen_HCU), 1);
    @(negedge clk);
    chk("t2_ready_back", int'(in_ready), 1);
    step();

    // T3: back-to-back same bin
    for (int i = 0; i < 3; i++) send(9, 1'b0);
    settle_and_check("t3");

    // T4: saturate bin 7, then a fresh bin keeps the sticky flag
    for (int i = 0; i < 300; i++) send(7, 1'b0);
    settle_and_check("t4_sat");
    chk("t4_ref7", ref_hist[7], MAXV);
    send(8, 1'b0);
    settle_and_check("t4_after");

    // Randomized samples with idle gaps, mostly colliding bins
    for (int i = 0; i < 200; i++) begin
      int b;
      b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                      : int'($urandom_range(0, 15));
      send(b, 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end
    settle_and_check("rand");

    // T5: last sample ends the run; further samples are ignored
    send(2, 1'b1);
    wait_done("t5");
    held_cnt = exp_cnt;
    in_valid = 1'b1;
    in_bin   = ADDR_W'(3);
    repeat (5) step();
    in_valid = 1'b0;
    chk("t5_cnt_hold", int'(sample_cnt), held_cnt);
    chk("t5_done_hold", int'(done), 1);
    step();

    // Restart and interrupt the clear with reset at address 100
    do_start(1'b0);
    hit = 1'b0;
    for (int g = 0; g < 200; g++) begin
      if (hist_wen_HCU && hist_addr_HCU == ADDR_W'(100)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t6_reach_100", int'(hit), 1);
    #2;
    rst_n = 1'b0;
    #1;
    wq.delete();
    rq.delete();
    chk_all_zero("t6_async");
    step();
    step();
    chk_all_zero("t6_held");
    rst_n = 1'b1;
    step();
    chk_all_zero("t6_release");

    do_start(1'b1);
    for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 7)), (i == 9));
    wait_done("final");
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
